// File: rtl/peak_regfile_pkg.sv
// peak_regfile_pkg: shared FSM states, AR select default and {task, reg} indexing
package peak_regfile_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_CLR} state_e;
  localparam logic [7:0] AR_REGADDR_DEF = 8'h10;
  localparam int REG_IDX_W = 5;
  function automatic int unsigned reg_idx(input int unsigned t, input logic [REG_IDX_W-1:0] r);
    return (t << REG_IDX_W) | 32'(r);
  endfunction
endpackage

// File: rtl/peak_regfile_bank.sv
// peak_regfile_bank: 1W1R synchronous-read array, write forwarding under PEAK_REGFILE_BYPASS_EN
module peak_regfile_bank #(
  parameter int DW = 32,
  parameter int AW = 6
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  input  logic          rzero,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_d, rdata_q;
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  always_comb begin
`ifdef PEAK_REGFILE_BYPASS_EN
    rdata_d = rzero ? '0 : (we && waddr == raddr) ? wdata : mem_q[raddr];
`else
    rdata_d = rzero ? '0 : mem_q[raddr];
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/peak_rv32_regfile_mt.sv
// peak_rv32_regfile_mt: multi-task RV32 regfile with debug port, init/clear FSM; PEAK_REGFILE_BYPASS_EN enables write forwarding
module peak_rv32_regfile_mt
  import peak_regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_TASKS = 2,
  parameter logic [7:0] AR_REGADDR = AR_REGADDR_DEF,
  localparam int TASK_W = $clog2(NUM_TASKS)
)(
  input  logic              CLK,
  input  logic              RST,
  input  logic [TASK_W-1:0] TASKNUM,
  input  logic [4:0]        WADDR,
  input  logic              WE,
  input  logic [XLEN-1:0]   WDATA,
  input  logic [4:0]        RS1ADDR,
  input  logic [4:0]        RS2ADDR,
  output logic [XLEN-1:0]   RS1,
  output logic [XLEN-1:0]   RS2,
  input  logic              TASK_CLR,
  input  logic [TASK_W-1:0] TASK_CLR_ID,
  output logic              BUSY,
  input  logic              AR_EN,
  input  logic              AR_WR,
  input  logic [15:0]       AR_AD,
  input  logic [TASK_W-1:0] AR_TASK,
  input  logic [XLEN-1:0]   AR_DI,
  output logic [XLEN-1:0]   AR_DO
);
  localparam int AW = TASK_W + REG_IDX_W;
  localparam int NUM_ENT = NUM_TASKS << REG_IDX_W;
  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [TASK_W-1:0] clr_id_q, clr_id_d;
  logic ar_rd_q, ar_rd_d;
  logic ar_hit, we, zero1, zero2, ar_ad_unused;
  logic [AW-1:0] waddr, raddr1, raddr2;
  logic [XLEN-1:0] wdata;
  assign ar_ad_unused = ^AR_AD[7:5];
  assign BUSY = state_q != ST_RUN;
  assign ar_hit = AR_EN && AR_AD[15:8] == AR_REGADDR;
  assign ar_rd_d = ar_hit && !AR_WR;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    clr_id_d = clr_id_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NUM_ENT - 1)) state_d = ST_RUN;
      end
      ST_RUN: if (TASK_CLR) begin
        state_d = ST_CLR;
        clr_id_d = TASK_CLR_ID;
        cnt_d = '0;
      end
      ST_CLR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q[REG_IDX_W-1:0] == '1) begin
          state_d = ST_RUN;
          cnt_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= ST_INIT;
      cnt_q <= '0;
      clr_id_q <= '0;
      ar_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      clr_id_q <= clr_id_d;
      ar_rd_q <= ar_rd_d;
    end
  // FSM zeroing owns the write port while busy; any AR strobe blocks the core
  always_comb begin
    we = 1'b0;
    waddr = AW'(reg_idx(32'(TASKNUM), WADDR));
    wdata = WDATA;
    if (BUSY) begin
      we = 1'b1;
      wdata = '0;
      waddr = state_q == ST_CLR ? AW'(reg_idx(32'(clr_id_q), cnt_q[REG_IDX_W-1:0])) : cnt_q;
    end else if (ar_hit && AR_WR) begin
      we = AR_AD[4:0] != '0;
      waddr = AW'(reg_idx(32'(AR_TASK), AR_AD[4:0]));
      wdata = AR_DI;
    end else if (!AR_EN) we = WE && WADDR != '0;
  end
  assign raddr1 = ar_rd_d ? AW'(reg_idx(32'(AR_TASK), AR_AD[4:0])) : AW'(reg_idx(32'(TASKNUM), RS1ADDR));
  assign raddr2 = AW'(reg_idx(32'(TASKNUM), RS2ADDR));
  assign zero1 = BUSY || (ar_rd_d ? AR_AD[4:0] == '0 : RS1ADDR == '0);
  assign zero2 = BUSY || RS2ADDR == '0;
  peak_regfile_bank #(.DW(XLEN), .AW(AW)) u_bank1 (
    .clk(CLK), .rst(RST), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr1), .rzero(zero1), .rdata(RS1)
  );
  peak_regfile_bank #(.DW(XLEN), .AW(AW)) u_bank2 (
    .clk(CLK), .rst(RST), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr2), .rzero(zero2), .rdata(RS2)
  );
  assign AR_DO = ar_rd_q ? RS1 : '0;
endmodule

// File: tb/tb_peak_rv32_regfile_mt.sv
// tb_peak_rv32_regfile_mt: directed self-checking bench for the multi-task register file
module tb_peak_rv32_regfile_mt;
  logic CLK, RST, TASKNUM, WE, TASK_CLR, TASK_CLR_ID, BUSY, AR_EN, AR_WR, AR_TASK;
  logic [4:0] WADDR, RS1ADDR, RS2ADDR;
  logic [31:0] WDATA, RS1, RS2, AR_DI, AR_DO;
  logic [15:0] AR_AD;
  int n_cmp = 0, n_fail = 0;

  peak_rv32_regfile_mt dut (
    .CLK(CLK), .RST(RST), .TASKNUM(TASKNUM), .WADDR(WADDR), .WE(WE), .WDATA(WDATA),
    .RS1ADDR(RS1ADDR), .RS2ADDR(RS2ADDR), .RS1(RS1), .RS2(RS2),
    .TASK_CLR(TASK_CLR), .TASK_CLR_ID(TASK_CLR_ID), .BUSY(BUSY),
    .AR_EN(AR_EN), .AR_WR(AR_WR), .AR_AD(AR_AD), .AR_TASK(AR_TASK), .AR_DI(AR_DI), .AR_DO(AR_DO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic core_wr(input logic t, input logic [4:0] r, input logic [31:0] d);
    TASKNUM = t; WADDR = r; WDATA = d; WE = 1'b1;
    tick;
    WE = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", BUSY); end
    n_cmp++; if (RS1 !== 32'h0) begin n_fail++; $display("FAIL rst_rs1: got %h want 0", RS1); end
    n_cmp++; if (AR_DO !== 32'h0) begin n_fail++; $display("FAIL rst_ardo: got %h want 0", AR_DO); end
    @(negedge CLK) RST = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick;
      n_cmp++; if (BUSY !== (i < 64)) begin n_fail++; $display("FAIL init_busy[%0d]: got %b want %b", i, BUSY, i < 64); end
    end
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 32; r++) begin
        TASKNUM = t[0]; RS1ADDR = r[4:0]; RS2ADDR = 5'(31 - r);
        tick;
        n_cmp++; if (RS1 !== 32'h0) begin n_fail++; $display("FAIL init_rs1 t%0d x%0d: got %h want 0", t, r, RS1); end
        n_cmp++; if (RS2 !== 32'h0) begin n_fail++; $display("FAIL init_rs2 t%0d x%0d: got %h want 0", t, 31 - r, RS2); end
      end
  endtask

  task automatic test_core_rw;
    core_wr(1'b1, 5'd5, 32'hDEADBEEF);
    RS1ADDR = 5'd5; tick;
    n_cmp++; if (RS1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_x5: got %h want deadbeef", RS1); end
    TASKNUM = 1'b0; tick;
    n_cmp++; if (RS1 !== 32'h0) begin n_fail++; $display("FAIL t0_x5: got %h want 0", RS1); end
    core_wr(1'b1, 5'd0, 32'h1234);
    RS1ADDR = 5'd0; RS2ADDR = 5'd0; tick;
    n_cmp++; if (RS1 !== 32'h0) begin n_fail++; $display("FAIL x0_rs1: got %h want 0", RS1); end
    n_cmp++; if (RS2 !== 32'h0) begin n_fail++; $display("FAIL x0_rs2: got %h want 0", RS2); end
  endtask

  task automatic test_ar;
    TASKNUM = 1'b1; WADDR = 5'd4; WDATA = 32'h777; WE = 1'b1;
    AR_EN = 1'b1; AR_WR = 1'b1; AR_AD = 16'h1003; AR_TASK = 1'b1; AR_DI = 32'hA5A5A5A5;
    tick;
    WE = 1'b0; AR_WR = 1'b0; TASKNUM = 1'b0; RS1ADDR = 5'd5;
    tick;
    n_cmp++; if (AR_DO !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL ar_do: got %h want a5a5a5a5", AR_DO); end
    n_cmp++; if (RS1 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL ar_rs1: got %h want a5a5a5a5", RS1); end
    AR_EN = 1'b0; TASKNUM = 1'b1; RS1ADDR = 5'd4;
    tick;
    n_cmp++; if (RS1 !== 32'h0) begin n_fail++; $display("FAIL ar_core_drop: got %h want 0", RS1); end
    n_cmp++; if (AR_DO !== 32'h0) begin n_fail++; $display("FAIL ar_do_idle: got %h want 0", AR_DO); end
    AR_EN = 1'b1; AR_WR = 1'b0; AR_AD = 16'h2003; RS1ADDR = 5'd5;
    tick;
    n_cmp++; if (AR_DO !== 32'h0) begin n_fail++; $display("FAIL ar_miss_do: got %h want 0", AR_DO); end
    n_cmp++; if (RS1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ar_miss_rs1: got %h want deadbeef", RS1); end
    AR_WR = 1'b1; AR_AD = 16'h2006; AR_DI = 32'h99; WADDR = 5'd6; WDATA = 32'h66; WE = 1'b1;
    tick;
    WE = 1'b0; AR_EN = 1'b0; AR_WR = 1'b0; RS1ADDR = 5'd6;
    tick;
    n_cmp++; if (RS1 !== 32'h0) begin n_fail++; $display("FAIL ar_miss_wr: got %h want 0", RS1); end
  endtask

  task automatic test_task_clr;
    for (int r = 1; r < 32; r++) core_wr(1'b1, r[4:0], 32'h1000_0000 + r);
    for (int r = 1; r < 32; r++) core_wr(1'b0, r[4:0], 32'h2000_0000 + r);
    TASKNUM = 1'b0; RS1ADDR = 5'd1; WADDR = 5'd2; WDATA = 32'hBAD;
    TASK_CLR = 1'b1; TASK_CLR_ID = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick;
      TASK_CLR = (i == 4); TASK_CLR_ID = 1'b0; WE = (i == 8);
      n_cmp++; if (BUSY !== (i <= 32)) begin n_fail++; $display("FAIL clr_busy[%0d]: got %b want %b", i, BUSY, i <= 32); end
      if (i == 1) begin
        n_cmp++; if (RS1 !== 32'h2000_0001) begin n_fail++; $display("FAIL clr_pre_rd: got %h want 20000001", RS1); end
      end
      if (i == 10) begin
        n_cmp++; if (RS1 !== 32'h0) begin n_fail++; $display("FAIL clr_busy_rd: got %h want 0", RS1); end
      end
    end
    AR_EN = 1'b1; AR_WR = 1'b0; AR_TASK = 1'b0; TASKNUM = 1'b1;
    for (int r = 1; r < 32; r++) begin
      AR_AD = {8'h10, 3'b000, r[4:0]}; RS2ADDR = r[4:0];
      tick;
      n_cmp++; if (RS2 !== 32'h0) begin n_fail++; $display("FAIL clr_t1 x%0d: got %h want 0", r, RS2); end
      n_cmp++; if (AR_DO !== 32'h2000_0000 + r) begin n_fail++; $display("FAIL clr_t0 x%0d: got %h want %h", r, AR_DO, 32'h2000_0000 + r); end
    end
    AR_EN = 1'b0;
  endtask

  task automatic test_bypass;
    core_wr(1'b0, 5'd7, 32'h11);
    WADDR = 5'd7; WDATA = 32'h55; WE = 1'b1; RS2ADDR = 5'd7; RS1ADDR = 5'd7;
    tick;
    WE = 1'b0;
`ifdef PEAK_REGFILE_BYPASS_EN
    n_cmp++; if (RS2 !== 32'h55) begin n_fail++; $display("FAIL same_cyc_rs2: got %h want 55", RS2); end
    n_cmp++; if (RS1 !== 32'h55) begin n_fail++; $display("FAIL same_cyc_rs1: got %h want 55", RS1); end
`else
    n_cmp++; if (RS2 !== 32'h11) begin n_fail++; $display("FAIL same_cyc_rs2: got %h want 11", RS2); end
    n_cmp++; if (RS1 !== 32'h11) begin n_fail++; $display("FAIL same_cyc_rs1: got %h want 11", RS1); end
`endif
    tick;
    n_cmp++; if (RS2 !== 32'h55) begin n_fail++; $display("FAIL after_wr_rs2: got %h want 55", RS2); end
  endtask

  task automatic test_reset_in_clr;
    core_wr(1'b1, 5'd9, 32'h99);
    TASK_CLR = 1'b1; TASK_CLR_ID = 1'b0;
    tick;
    TASK_CLR = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    RST = 1'b1;
    #1;
    n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL rst_clr_busy: got %b want 1", BUSY); end
    n_cmp++; if (RS2 !== 32'h0) begin n_fail++; $display("FAIL rst_clr_rs2: got %h want 0", RS2); end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick;
      n_cmp++; if (BUSY !== (i < 64)) begin n_fail++; $display("FAIL reinit_busy[%0d]: got %b want %b", i, BUSY, i < 64); end
    end
    TASKNUM = 1'b1; RS1ADDR = 5'd9; RS2ADDR = 5'd7;
    tick;
    n_cmp++; if (RS1 !== 32'h0) begin n_fail++; $display("FAIL reinit_t1x9: got %h want 0", RS1); end
    TASKNUM = 1'b0; RS1ADDR = 5'd20;
    tick;
    n_cmp++; if (RS1 !== 32'h0) begin n_fail++; $display("FAIL reinit_t0x20: got %h want 0", RS1); end
    n_cmp++; if (RS2 !== 32'h0) begin n_fail++; $display("FAIL reinit_t0x7: got %h want 0", RS2); end
  endtask

  initial begin
    RST = 1'b1; TASKNUM = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0; RS1ADDR = '0; RS2ADDR = '0;
    TASK_CLR = 1'b0; TASK_CLR_ID = 1'b0; AR_EN = 1'b0; AR_WR = 1'b0; AR_AD = '0; AR_TASK = 1'b0; AR_DI = '0;
    test_reset;
    test_core_rw;
    test_ar;
    test_task_clr;
    test_bypass;
    test_reset_in_clr;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/peak_rv32_regfile_mt.md
Name: peak_rv32_regfile_mt

Overview:
Parametrised multi-task RV32 integer register file: NUM_TASKS hardware contexts of 32 x XLEN registers, two synchronous read ports and one write port.
- Debug (AR) port for register read/write with a selectable task.
- Hardware zero-initialisation after reset and a per-task clear command sequenced by a small FSM.
- Sits between decode (RS1/RS2) and writeback in the peak core; the AR bus comes from the debug/host interface.

Parameters:
XLEN, 32, register width in bits
NUM_TASKS, 2, number of hardware task contexts (power of two, >= 2)
AR_REGADDR, 8'h10, AR_AD[15:8] value that selects this block on the AR bus
TASK_W (localparam), $clog2(NUM_TASKS), task index width

Ports:
CLK  in  1  clock, all logic rising-edge
RST  in  1  asynchronous, active-high reset
TASKNUM  in  TASK_W  task context for core read/write
WADDR  in  5  core write register index
WE  in  1  core write enable
WDATA  in  XLEN  core write data
RS1ADDR  in  5  read port 1 index
RS2ADDR  in  5  read port 2 index
RS1  out  XLEN  read port 1 data, 1-cycle latency
RS2  out  XLEN  read port 2 data, 1-cycle latency
TASK_CLR  in  1  pulse: zero all registers of TASK_CLR_ID
TASK_CLR_ID  in  TASK_W  task to clear
BUSY  out  1  init/clear in progress; core must stall
AR_EN  in  1  debug access strobe
AR_WR  in  1  debug write (1) / read (0)
AR_AD  in  16  debug address; [15:8] block select, [4:0] register index
AR_TASK  in  TASK_W  debug task context
AR_DI  in  XLEN  debug write data
AR_DO  out  XLEN  debug read data, 1-cycle latency

Behaviour:
- Storage: two identical arrays of NUM_TASKS*32 entries, indexed {task, reg}, one per read port. Every write goes to both arrays.
- Reset values: RS1/RS2/AR_DO registered data = 0, BUSY = 1, FSM = INIT, counter = 0.
- FSM states:
  - INIT: writes 0 to entry counter (both arrays), counter++ each cycle. After entry NUM_TASKS*32-1 -> RUN. Lasts exactly NUM_TASKS*32 cycles after RST falls.
  - RUN: BUSY = 0. TASK_CLR=1 -> CLR, latch TASK_CLR_ID, counter = 0.
  - CLR: writes 0 to {latched id, counter[4:0]}. After index 31 -> RUN. Lasts 32 cycles; BUSY = 1.
- TASK_CLR outside RUN is ignored (no queueing).
- Async RST in any state -> INIT, counter 0; any in-flight clear is abandoned.
- While BUSY: core WE and AR writes are dropped; RS1/RS2/AR_DO return 0.
- AR_HIT = AR_EN & (AR_AD[15:8]==AR_REGADDR).
  - Any AR_EN=1 suppresses core WE that cycle.
  - AR write when AR_HIT & AR_WR: target {AR_TASK, AR_AD[4:0]}.
  - AR read when AR_HIT & !AR_WR: read port 1 uses {AR_TASK, AR_AD[4:0]}. Result appears next cycle on both AR_DO and RS1.
  - AR_EN without hit: no write, RS1 keeps core addressing, AR_DO = 0 next cycle.
- Register x0: writes to index 0 are dropped; a read of index 0 returns 0. The zero flag is registered alongside the read address.
- Read latency: address at cycle N -> data valid during cycle N+1. Output is held while the address is unchanged.
- Same-cycle write and read of the same {task, reg}: returns OLD data unless the optional feature is enabled.

Optional Feature:
PEAK_REGFILE_BYPASS_EN
- Defined: when a qualified write (not BUSY, index != 0) matches a read port's {task, reg} in the same cycle, that port returns the write data next cycle. Applies to RS1, RS2 and AR_DO.
- Undefined: no forwarding; the port returns pre-write contents.

Decomposition:
- Package peak_regfile_pkg: state enum (INIT, RUN, CLR), AR_REGADDR default, REG_IDX_W=5, function for the {task, reg} index.
- One sub-module, peak_regfile_bank: a single 1W1R synchronous-read array with optional bypass, instantiated twice.

Test Plan:
- Reset, NUM_TASKS=2: BUSY=1 for exactly 64 cycles after RST falls. Then read every register of both tasks -> all 0.
- TASKNUM=1, WE write x5=0xDEADBEEF; next cycle read RS1ADDR=5 -> RS1=0xDEADBEEF. Task 0 x5 still 0. Write x0=0x1234 -> reading x0 gives 0.
- AR_EN=1, AR_WR=1, AR_AD=0x1003, AR_TASK=1, AR_DI=0xA5A5A5A5, with core WE=1 same cycle -> core write dropped. AR read of 0x1003 -> AR_DO=0xA5A5A5A5 one cycle later.
- Load task 1 x1..x31 with nonzero values; pulse TASK_CLR id=1 -> BUSY high 32 cycles; task 1 reads 0, task 0 unchanged. A second TASK_CLR during CLR is ignored.
- Same-cycle WE x7=0x55 and RS2ADDR=7 (old value 0x11) -> RS2=0x11 without bypass, 0x55 with PEAK_REGFILE_BYPASS_EN.
- Assert RST during CLR at counter 10 -> BUSY stays 1, FSM restarts INIT, full NUM_TASKS*32-cycle zeroing completes.
